sync_fifo: RTL
==============

# sync_fifo

Parametrised single-clock FIFO: the next generation of the team's buffer block, generalised in width and depth, with occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, synchronous flush and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain, for example ahead of a packet framer or behind a DMA read port.

## Interface
- `DATA_WIDTH`, default 16: word width.
- `DEPTH`, default 512: number of words; must be a power of two and ≥ 4.
- `ADDR_SIZE`, default `$clog2(DEPTH)`: derived; do not override.
- `FWFT`, default 0: 0 selects the standard registered read; 1 selects first-word-fall-through.
- `AF_LEVEL`, default `DEPTH-4`: `almost_full` asserts when `count >= AF_LEVEL`.
- `AE_LEVEL`, default 4: `almost_empty` asserts when `count <= AE_LEVEL`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous flush.
- `wr_en`, in, 1: write request.
- `din`, in, DATA_WIDTH: write data.
- `rd_en`, in, 1: read request.
- `dout`, out, DATA_WIDTH: read data.
- `valid`, out, 1: `dout` is valid.
- `full`, `empty`, out, 1: status flags.
- `almost_full`, `almost_empty`, out, 1: threshold flags.
- `count`, out, ADDR_SIZE+1: words stored, 0..DEPTH.
- `overflow`, `underflow`, out, 1: one-cycle error pulses.

## Operation
- **Pointers.** `wr_ptr` and `rd_ptr` are ADDR_SIZE bits and wrap naturally from DEPTH-1 to 0.
- **Count and flags.** `count` is a register. `full = (count == DEPTH)` and `empty = (count == 0)`, both decoded from `count`.
- **Write.** Accepted iff `wr_en && (!full || rd_accept)`. An accepted write stores `din` at `mem[wr_ptr]` and increments `wr_ptr`.
- **Read.** Accepted iff `rd_en && !empty`. An accepted read increments `rd_ptr`.
- **Count update.** +1 on write only, −1 on read only, unchanged on both or neither.
- **Simultaneous write and read.**
  - When full: both are accepted; `count` stays at DEPTH.
  - When empty: the write is accepted; the read is rejected and `underflow` pulses.
- **Error pulses.** `overflow` pulses when `wr_en && full && !rd_en`. `underflow` pulses when `rd_en && empty`.
- **Read data, FWFT=0.**
  - On an accepted read, `dout <= mem[rd_ptr]` and `valid` pulses high for one cycle.
  - Otherwise `dout` holds its value and `valid` is 0.
- **Read data, FWFT=1.**
  - `dout = mem[rd_ptr]` (combinational read) and `valid = !empty`.
  - `rd_en` acts as a pop/acknowledge of the word currently on `dout`.
- **Flush (`clr`).** Clears pointers, `count`, `valid`, `overflow` and `underflow`. Writes and reads in the same cycle are ignored. Memory contents are not cleared; `dout` holds its value in FWFT=0.
- **Reset (`rst_n` low).** `count=0`, pointers 0, `dout=0`, `valid=0`, `overflow=0`, `underflow=0`, `empty=1`, `full=0`, `almost_empty=1`, `almost_full=0`. Reset applies immediately at any point, including mid-burst; memory is not reset.

## Timing
- Every flag and `count` is registered-derived and reflects accepted operations with 1 cycle latency.
- **Write to non-empty.** A write at edge N makes `empty=0` after edge N.
- **FWFT=1.** A word written at edge N is on `dout` with `valid=1` after edge N.
- **FWFT=0.** `rd_en` sampled at edge N gives `dout`/`valid` after edge N.
- **Sustained throughput.** One write and one read per cycle.
- **Reset release.** Must be synchronised externally to `clk`; the first write is accepted on the first edge after `rst_n` rises.

## Structure
- **Package `sync_fifo_pkg`:** the `fifo_mode_e` enum (`FIFO_STD`, `FIFO_FWFT`) and the default threshold margin constant (4).
- **Sub-module `fifo_mem`:** a simple dual-port array with one write port and one read port, plus a parameter choosing synchronous or asynchronous read. It holds no reset on the array.
- **Top level:** pointers, count, flags and error logic.

## Test plan
All scenarios use `DEPTH=8` and `DATA_WIDTH=16`.
- **Reset defaults.** Assert `rst_n` low asynchronously mid-cycle → all outputs take their reset values immediately. Release, then write `0x0001` → `count=1` and `empty=0` next cycle.
- **Fill and overflow.** Write `0x0000`..`0x0007` → `full=1` and `almost_full=1` from `count=4`. A 9th write without `rd_en` → `overflow` pulses once and `count` stays 8.
- **Drain and underflow (FWFT=0).** Read 8 times from full → data `0x0000`..`0x0007` in order, each 1 cycle after its `rd_en`. A 9th `rd_en` → `underflow` pulses, `valid=0`, `dout` holds `0x0007`.
- **Simultaneous access.**
  - When full: wr+rd in the same cycle → `count` stays 8 and no overflow.
  - When empty: wr+rd in the same cycle → `count=1` and `underflow` pulses.
- **Wrap-around.** Stream 20 words with a 1-cycle lag between write and read → output equals input and `count` never exceeds 2.
- **FWFT and flush.** With `FWFT=1`, write `0xABCD` → `dout=0xABCD`, `valid=1` next cycle. Then pulse `clr` with `wr_en` high → `count=0`, `valid=0`, and the write is dropped.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types and constants for the sync_fifo buffer family.
//   fifo_mode_e   : read-side behaviour (registered read or first-word-fall-through)
//   THRESH_MARGIN : default distance of the almost-full / almost-empty
//                   thresholds from the full / empty boundaries
//   to_mode()     : maps the integer FWFT parameter onto fifo_mode_e
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned THRESH_MARGIN = 32'd4;

  // Any non-zero FWFT selection means fall-through mode.
  function automatic fifo_mode_e to_mode(input int unsigned fwft);
    fifo_mode_e mode;
    if (fwft != 32'd0) begin
      mode = FIFO_FWFT;
    end else begin
      mode = FIFO_STD;
    end
    return mode;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array: one write port, one read port, same clock.
// The array itself carries no reset. READ_MODE selects the read port style:
//   FIFO_STD  : registered read, rd_data updates on clk when rd_en is high and
//               holds otherwise; the output register resets to zero.
//   FIFO_FWFT : combinational read, rd_data = mem[rd_addr] at all times.
// Ports
//   clk, rst_n          : clock, async active-low reset (output register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read port control
//   rd_data             : read data
// -----------------------------------------------------------------------------
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32'd16,
  parameter int unsigned DEPTH      = 32'd512,
  parameter int unsigned ADDR_SIZE  = $clog2(DEPTH),
  parameter fifo_mode_e  READ_MODE  = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_SIZE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage array write port (deliberately unreset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  if (READ_MODE == FIFO_STD) begin : g_sync_read
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Registered read port: load on rd_en, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
        rd_data_r <= mem_r[rd_addr];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end

    assign rd_data = rd_data_r;
  end else begin : g_async_read
    // rd_en and rst_n only act on the output register of the registered mode.
    logic unused_ctrl_s;
    assign unused_ctrl_s = rd_en ^ rst_n;
    assign rd_data       = mem_r[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses, synchronous flush and a selectable
// first-word-fall-through read mode. DEPTH must be a power of two and >= 4.
// Ports
//   clk, rst_n      : clock (rising edge), async active-low reset
//   clr             : synchronous flush (pointers, count, valid, error pulses)
//   wr_en, din      : write request and data
//   rd_en           : read request (pop/acknowledge in FWFT mode)
//   dout, valid     : read data and its qualifier
//   full, empty     : status flags
//   almost_full     : count >= AF_LEVEL
//   almost_empty    : count <= AE_LEVEL
//   count           : words stored, 0..DEPTH
//   overflow        : one-cycle pulse, write attempted while full without read
//   underflow       : one-cycle pulse, read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32'd16,
  parameter int unsigned DEPTH      = 32'd512,
  parameter int unsigned ADDR_SIZE  = $clog2(DEPTH),
  parameter int unsigned FWFT       = 32'd0,
  parameter int unsigned AF_LEVEL   = DEPTH - THRESH_MARGIN,
  parameter int unsigned AE_LEVEL   = THRESH_MARGIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned       CNT_W    = ADDR_SIZE + 32'd1;
  localparam fifo_mode_e        MODE     = to_mode(FWFT);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  CNT_AE   = CNT_W'(AE_LEVEL);
  localparam logic [ADDR_SIZE-1:0] PTR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [ADDR_SIZE-1:0] PTR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  // State registers
  logic [ADDR_SIZE-1:0] wr_ptr_r;
  logic [ADDR_SIZE-1:0] rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 empty_r;
  logic                 full_r;
  logic                 almost_empty_r;
  logic                 almost_full_r;
  logic                 valid_r;
  logic                 overflow_r;
  logic                 underflow_r;

  // Next-state signals
  logic                 wr_accept_s;
  logic                 rd_accept_s;
  logic                 overflow_nx_s;
  logic                 underflow_nx_s;
  logic [ADDR_SIZE-1:0] wr_ptr_nx_s;
  logic [ADDR_SIZE-1:0] rd_ptr_nx_s;
  logic [CNT_W-1:0]     count_nx_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Handshake acceptance and error detection; a flush swallows everything.
  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge.
  always_comb begin
    wr_accept_s    = 1'b0;
    rd_accept_s    = 1'b0;
    overflow_nx_s  = 1'b0;
    underflow_nx_s = 1'b0;
    if (!clr) begin
      rd_accept_s    = rd_en && !empty_r;
      wr_accept_s    = wr_en && (!full_r || rd_accept_s);
      overflow_nx_s  = wr_en && full_r && !rd_en;
      underflow_nx_s = rd_en && empty_r;
    end else begin
      wr_accept_s    = 1'b0;
      rd_accept_s    = 1'b0;
      overflow_nx_s  = 1'b0;
      underflow_nx_s = 1'b0;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    count_nx_s  = count_r;
    if (clr) begin
      wr_ptr_nx_s = PTR_ZERO;
      rd_ptr_nx_s = PTR_ZERO;
      count_nx_s  = CNT_ZERO;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nx_s = wr_ptr_r;
      end
      if (rd_accept_s) begin
        rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nx_s = rd_ptr_r;
      end
      case ({wr_accept_s, rd_accept_s})
        2'b10:   count_nx_s = count_r + CNT_ONE;
        2'b01:   count_nx_s = count_r - CNT_ONE;
        default: count_nx_s = count_r;
      endcase
    end
  end

  // Registered state; flags are decoded from the next count so they land on
  // the same edge as the count itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      count_r        <= CNT_ZERO;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
      valid_r        <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nx_s;
      rd_ptr_r       <= rd_ptr_nx_s;
      count_r        <= count_nx_s;
      empty_r        <= (count_nx_s == CNT_ZERO);
      full_r         <= (count_nx_s == CNT_FULL);
      almost_empty_r <= (count_nx_s <= CNT_AE);
      almost_full_r  <= (count_nx_s >= CNT_AF);
      valid_r        <= rd_accept_s;
      overflow_r     <= overflow_nx_s;
      underflow_r    <= underflow_nx_s;
    end
  end

  // Registered read in standard mode, combinational read in FWFT mode.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .READ_MODE  (MODE)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept_s),
    .wr_addr (wr_ptr_r),
    .wr_data (din),
    .rd_en   (rd_accept_s),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  assign dout         = rd_data_s;
  // In FWFT mode the head word is on dout whenever something is stored.
  assign valid        = (MODE == FIFO_FWFT) ? !empty_r : valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
